tug_referee: RTL and testbench



---
 rtl/tug_referee.sv | 159 +++++++++++++++
 tb/tb_tug_referee.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tug_referee.sv
// tug_referee: tug-of-war game control. Arbitrates left/right press pulses,
// moves the playfield light, latches the round winner and keeps saturating
// per-player win counts.
// Optional feature macro: TUG_AUTO_RESTART_EN (auto-return to PLAY after
// RESTART_CYCLES cycles in a win state).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   PLAY  | round in progress, light at pos, presses move it
//   L_WON | left player pushed past the last light, presses ignored
//   R_WON | right player pushed past light 0, presses ignored
module tug_referee #(
  parameter int NUM_LIGHTS     = 9,
  parameter int RESTART_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_press,
  input  logic                  r_press,
  input  logic                  new_round,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic [1:0]            winner,
  output logic                  game_over,
  output logic [2:0]            l_score,
  output logic [2:0]            r_score
);

  localparam int PW = $clog2(NUM_LIGHTS);
  localparam logic [PW-1:0] CENTER = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LIGHTS - 1);

  // Elaboration-time parameter sanity checks
  if (NUM_LIGHTS < 3 || (NUM_LIGHTS % 2) == 0) begin : g_bad_lights
    $error("tug_referee: NUM_LIGHTS must be odd and >= 3");
  end
  if (RESTART_CYCLES < 1) begin : g_bad_restart
    $error("tug_referee: RESTART_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    PLAY  = 2'b00,
    L_WON = 2'b01,
    R_WON = 2'b10
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pos, pos_n;
  logic [2:0]    l_score_n, r_score_n;
  logic          l_move, r_move;

  // Simultaneous presses cancel; only a lone press is a move.
  assign l_move = l_press & ~r_press;
  assign r_move = r_press & ~l_press;

`ifdef TUG_AUTO_RESTART_EN
  localparam int CW = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  logic [CW-1:0] restart_cnt, restart_cnt_n;
  logic          restart_tc;
  assign restart_tc = (restart_cnt == '0);
`endif

  // State, position, score and restart-timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PLAY;
      pos     <= CENTER;
      l_score <= 3'd0;
      r_score <= 3'd0;
`ifdef TUG_AUTO_RESTART_EN
      restart_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      pos     <= pos_n;
      l_score <= l_score_n;
      r_score <= r_score_n;
`ifdef TUG_AUTO_RESTART_EN
      restart_cnt <= restart_cnt_n;
`endif
    end
  end

  // Next-state logic: move arbitration, win detection, round restart
  always_comb begin
    state_n   = state;
    pos_n     = pos;
    l_score_n = l_score;
    r_score_n = r_score;
    case (state)
      PLAY: begin
        if (new_round) begin
          pos_n = CENTER;
        end else if (l_move) begin
          if (pos == LAST) begin
            state_n   = L_WON;
            l_score_n = (l_score == 3'd7) ? l_score : l_score + 3'd1;
          end else begin
            pos_n = pos + PW'(1);
          end
        end else if (r_move) begin
          if (pos == '0) begin
            state_n   = R_WON;
            r_score_n = (r_score == 3'd7) ? r_score : r_score + 3'd1;
          end else begin
            pos_n = pos - PW'(1);
          end
        end
      end
      L_WON, R_WON: begin
        if (new_round) begin
          state_n = PLAY;
          pos_n   = CENTER;
        end
`ifdef TUG_AUTO_RESTART_EN
        else if (restart_tc) begin
          state_n = PLAY;
          pos_n   = CENTER;
        end
`endif
      end
      default: begin
        state_n = PLAY;
        pos_n   = CENTER;
      end
    endcase
  end

`ifdef TUG_AUTO_RESTART_EN
  // Restart down-counter: loaded on win entry, counts to terminal zero
  always_comb begin
    restart_cnt_n = restart_cnt;
    if (state == PLAY && state_n != PLAY) begin
      restart_cnt_n = CW'(RESTART_CYCLES - 1);
    end else if (state != PLAY && !restart_tc) begin
      restart_cnt_n = restart_cnt - CW'(1);
    end
  end
`endif

  // Output decode from registered state only
  always_comb begin
    leds      = '0;
    winner    = 2'b00;
    game_over = 1'b0;
    case (state)
      PLAY:    leds = NUM_LIGHTS'(1) << pos;
      L_WON: begin
        winner    = 2'b01;
        game_over = 1'b1;
      end
      R_WON: begin
        winner    = 2'b10;
        game_over = 1'b1;
      end
      default: leds = '0;
    endcase
  end

endmodule

// File: tb/tb_tug_referee.sv
// Testbench for tug_referee: directed scenarios with literal expectations,
// then randomized presses checked every cycle against a behavioural model.
module tb_tug_referee;

  localparam int N  = 9;
  localparam int C  = (N - 1) / 2;
  localparam int RC = 50;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         l_press = 1'b0;
  logic         r_press = 1'b0;
  logic         new_round = 1'b0;
  logic [N-1:0] leds;
  logic [1:0]   winner;
  logic         game_over;
  logic [2:0]   l_score;
  logic [2:0]   r_score;

  int n_checks = 0;
  int n_pass   = 0;

  // model: winner code 0 none, 1 left, 2 right; age = cycles spent in win
  int m_pos = C;
  int m_win = 0;
  int m_ls  = 0;
  int m_rs  = 0;
  int m_age = 0;

  tug_referee #(.NUM_LIGHTS(N), .RESTART_CYCLES(RC)) dut (
    .clk(clk), .reset(reset), .l_press(l_press), .r_press(r_press),
    .new_round(new_round), .leds(leds), .winner(winner),
    .game_over(game_over), .l_score(l_score), .r_score(r_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cyc(input logic l, input logic r, input logic nr);
    l_press = l; r_press = r; new_round = nr;
    @(posedge clk); #1;
    l_press = 1'b0; r_press = 1'b0; new_round = 1'b0;
  endtask

  // Behavioural model update at each edge, compare on the following negedge
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pos = C; m_win = 0; m_ls = 0; m_rs = 0; m_age = 0;
      end else if (m_win == 0) begin
        if (new_round) m_pos = C;
        else if (l_press && !r_press) begin
          if (m_pos == N - 1) begin
            m_win = 1; m_age = 0;
            if (m_ls < 7) m_ls = m_ls + 1;
          end else m_pos = m_pos + 1;
        end else if (r_press && !l_press) begin
          if (m_pos == 0) begin
            m_win = 2; m_age = 0;
            if (m_rs < 7) m_rs = m_rs + 1;
          end else m_pos = m_pos - 1;
        end
      end else begin
        m_age = m_age + 1;
        if (new_round) begin
          m_win = 0; m_pos = C;
        end
`ifdef TUG_AUTO_RESTART_EN
        else if (m_age >= RC) begin
          m_win = 0; m_pos = C;
        end
`endif
      end
      @(negedge clk);
      chk("model_leds", int'(leds), (m_win == 0) ? (1 << m_pos) : 0);
      chk("model_winner", int'(winner), m_win);
      chk("model_game_over", int'(game_over), (m_win != 0) ? 1 : 0);
      chk("model_l_score", int'(l_score), m_ls);
      chk("model_r_score", int'(r_score), m_rs);
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
    chk("reset_leds", int'(leds), 32'h010);
    chk("reset_winner", int'(winner), 0);
    chk("reset_scores", int'({l_score, r_score}), 0);

    repeat (4) cyc(1, 0, 0);
    chk("l4_leds", int'(leds), 32'h100);
    chk("l4_winner", int'(winner), 0);

    cyc(0, 0, 1);
    chk("nr_centre", int'(leds), 32'h010);
    repeat (4) cyc(0, 1, 0);
    chk("r4_leds", int'(leds), 32'h001);
    cyc(0, 1, 0);
    chk("r5_leds", int'(leds), 0);
    chk("r5_winner", int'(winner), 2);
    chk("r5_game_over", int'(game_over), 1);
    chk("r5_r_score", int'(r_score), 1);

    cyc(0, 0, 1);
    repeat (3) cyc(1, 1, 0);
    chk("both_cancel", int'(leds), 32'h010);
    repeat (5) cyc(1, 0, 0);
    chk("lwin_winner", int'(winner), 1);
    cyc(0, 0, 1);
    chk("lwin_nr_leds", int'(leds), 32'h010);
    chk("lwin_nr_l_score", int'(l_score), 1);

    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      repeat (5) cyc(1, 0, 0);
      cyc(0, 1, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 0);
    end
    chk("sat_l_score", int'(l_score), 7);
    chk("sat_r_score", int'(r_score), 1);
    chk("sat_leds", int'(leds), 0);
    chk("sat_winner", int'(winner), 1);

    cyc(0, 0, 1);
    repeat (2) cyc(1, 0, 0);
    chk("pos6_leds", int'(leds), 32'h040);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_leds", int'(leds), 32'h010);
    chk("midreset_scores", int'({l_score, r_score}), 0);
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    chk("nr_priority", int'(leds), 32'h010);

    repeat (5) cyc(1, 0, 0);
    chk("hold_go_start", int'(game_over), 1);
`ifdef TUG_AUTO_RESTART_EN
    repeat (RC - 1) cyc(0, 0, 0);
    chk("auto_go_last", int'(game_over), 1);
    cyc(0, 0, 0);
    chk("auto_go_end", int'(game_over), 0);
    chk("auto_leds", int'(leds), 32'h010);
`else
    repeat (200) cyc(0, 0, 0);
    chk("hold_go_200", int'(game_over), 1);
    chk("hold_leds_200", int'(leds), 0);
`endif
    cyc(0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      l_press   = ($urandom_range(0, 99) < 45);
      r_press   = ($urandom_range(0, 99) < 40);
      new_round = ($urandom_range(0, 39) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      @(posedge clk); #1;
    end
    l_press = 1'b0; r_press = 1'b0; new_round = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
